// File: rtl/fused_seq_issuer.sv
// fused_seq_issuer: expands one fused-sequence request into a stream of
// registered micro-ops read from per-case lookup tables.
// Optional feature macro: FUSED_SEQ_PERF_CNT_EN adds perf_uops/perf_seqs.

package len_table_pkg;
  typedef enum logic [2:0] {
    OP_NOP = 3'd0, OP_ADD = 3'd1, OP_IMUL = 3'd2, OP_AND = 3'd3,
    OP_OR  = 3'd4, OP_XOR = 3'd5, OP_SHL  = 3'd6
  } op_t;

  localparam int N_CASE  = 6;
  localparam int MAX_LEN = 8;

  localparam op_t OPS_LUT [N_CASE][MAX_LEN] = '{
    '{OP_IMUL, OP_ADD,  OP_NOP,  OP_NOP, OP_NOP, OP_NOP, OP_NOP, OP_NOP},
    '{OP_AND,  OP_AND,  OP_NOP,  OP_NOP, OP_NOP, OP_NOP, OP_NOP, OP_NOP},
    '{OP_ADD,  OP_SHL,  OP_ADD,  OP_XOR, OP_NOP, OP_NOP, OP_NOP, OP_NOP},
    '{OP_XOR,  OP_NOP,  OP_NOP,  OP_NOP, OP_NOP, OP_NOP, OP_NOP, OP_NOP},
    '{OP_IMUL, OP_IMUL, OP_IMUL, OP_ADD, OP_ADD, OP_ADD, OP_NOP, OP_NOP},
    '{OP_ADD,  OP_ADD,  OP_ADD,  OP_NOP, OP_NOP, OP_NOP, OP_NOP, OP_NOP}
  };

  localparam logic [31:0] IMM_LUT [N_CASE][MAX_LEN] = '{
    '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
    '{32'h0000_ffff, 32'h0000_00ff, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
    '{32'h5, 32'h2, 32'h0, 32'h0000_dead, 32'h0, 32'h0, 32'h0, 32'h0},
    '{32'hffff_ffff, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
    '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
    '{32'h1, 32'h2, 32'h3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}
  };

  // Bit i of each mask belongs to uop index i.
  localparam logic [MAX_LEN-1:0] USE_IMM_LUT [N_CASE] =
    '{8'h00, 8'h03, 8'h0b, 8'h01, 8'h00, 8'h07};
  localparam logic [MAX_LEN-1:0] FF_MASK_LUT [N_CASE] =
    '{8'h00, 8'h00, 8'h02, 8'h00, 8'h07, 8'h00};
  localparam logic [3:0] LEN_LUT   [N_CASE] = '{4'd2, 4'd2, 4'd4, 4'd1, 4'd6, 4'd3};
  localparam logic [2:0] STAGE_LUT [N_CASE] = '{3'd1, 3'd1, 3'd2, 3'd1, 3'd4, 3'd1};
endpackage

module fused_seq_issuer
  import len_table_pkg::*;
#(
  parameter int IDW = 3,
  parameter int DW  = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [IDW-1:0] req_case,
  input  logic [DW-1:0]  req_a,
  input  logic [DW-1:0]  req_b,
  output logic           uop_valid,
  input  logic           uop_ready,
  output op_t            uop_op,
  output logic [31:0]    uop_imm,
  output logic           uop_use_imm,
  output logic [DW-1:0]  uop_a,
  output logic [DW-1:0]  uop_b,
  output logic           uop_ff,
  output logic [2:0]     uop_stage,
  output logic           uop_last,
  output logic           busy,
  output logic           err
`ifdef FUSED_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]    perf_uops,
  output logic [31:0]    perf_seqs
`endif
);
  localparam int CW = $clog2(N_CASE);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] case_q, case_d, lut_case;
  logic [2:0]    idx_q, idx_d, lut_idx;
  logic [2:0]    stage_q, stage_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  op_t           op_q, op_d;
  logic [31:0]   imm_q, imm_d;
  logic          use_imm_q, use_imm_d, ff_q, ff_d, last_q, last_d;
  logic          valid_q, valid_d, ready_q, ready_d, err_q, err_d;
  logic          accept, legal, hs, load, clear;

  assign accept = req_valid & ready_q;
  assign legal  = {1'b0, req_case} < (IDW+1)'(N_CASE);
  assign hs     = valid_q & uop_ready;

  // Next-state, index/stage bookkeeping and registered uop field loads.
  always_comb begin
    state_d   = state_q;
    case_d    = case_q;
    idx_d     = idx_q;
    stage_d   = stage_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    ff_d      = ff_q;
    last_d    = last_q;
    err_d     = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    lut_case  = case_q;
    lut_idx   = idx_q + 3'd1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            state_d  = ISSUE;
            case_d   = req_case[CW-1:0];
            idx_d    = '0;
            stage_d  = '0;
            a_d      = req_a;
            b_d      = req_b;
            lut_case = req_case[CW-1:0];
            lut_idx  = '0;
            load     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (hs) begin
          if (last_q) begin
            state_d = IDLE;
            clear   = 1'b1;
          end else begin
            // Only non-last handshakes advance, so the table is never read past its length.
            idx_d   = idx_q + 3'd1;
            stage_d = stage_q + {2'b0, ff_q};
            load    = 1'b1;
          end
        end
      end
    endcase
    if (load) begin
      op_d      = OPS_LUT[lut_case][lut_idx];
      imm_d     = IMM_LUT[lut_case][lut_idx];
      use_imm_d = USE_IMM_LUT[lut_case][lut_idx];
      ff_d      = FF_MASK_LUT[lut_case][lut_idx];
      last_d    = ({1'b0, lut_idx} == (LEN_LUT[lut_case] - 4'd1));
    end else if (clear) begin
      op_d      = OP_NOP;
      imm_d     = '0;
      use_imm_d = 1'b0;
      ff_d      = 1'b0;
      last_d    = 1'b0;
      a_d       = '0;
      b_d       = '0;
      idx_d     = '0;
      stage_d   = '0;
    end
    valid_d = (state_d == ISSUE);
    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset abandons any sequence at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      case_q    <= '0;
      idx_q     <= '0;
      stage_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_NOP;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      ff_q      <= 1'b0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      case_q    <= case_d;
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
      ff_q      <= ff_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign req_ready   = ready_q;
  assign uop_valid   = valid_q;
  assign uop_op      = op_q;
  assign uop_imm     = imm_q;
  assign uop_use_imm = use_imm_q;
  assign uop_a       = a_q;
  assign uop_b       = b_q;
  assign uop_ff      = ff_q;
  assign uop_stage   = stage_q;
  assign uop_last    = last_q;
  assign busy        = (state_q == ISSUE);
  assign err         = err_q;

`ifdef FUSED_SEQ_PERF_CNT_EN
  logic [31:0] perf_uops_q, perf_uops_d, perf_seqs_q, perf_seqs_d;

  // Free-running wrap-around event counters.
  always_comb begin
    perf_uops_d = perf_uops_q + {31'b0, hs};
    perf_seqs_d = perf_seqs_q + {31'b0, hs & last_q};
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_uops_q <= '0;
      perf_seqs_q <= '0;
    end else begin
      perf_uops_q <= perf_uops_d;
      perf_seqs_q <= perf_seqs_d;
    end
  end

  assign perf_uops = perf_uops_q;
  assign perf_seqs = perf_seqs_q;
`endif
endmodule

// File: tb/tb_fused_seq_issuer.sv
// Self-checking bench for fused_seq_issuer: directed scenarios plus random
// sequences checked against a table-driven reference of the uop stream.
module tb_fused_seq_issuer;
  import len_table_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, uop_ready = 1'b0;
  logic [2:0]  req_case = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready, uop_valid, uop_use_imm, uop_ff, uop_last, busy, err;
  op_t         uop_op;
  logic [31:0] uop_imm, uop_a, uop_b;
  logic [2:0]  uop_stage;
`ifdef FUSED_SEQ_PERF_CNT_EN
  logic [31:0] perf_uops, perf_seqs;
`endif

  int checks = 0, errors = 0;
  int model_uops = 0, model_seqs = 0;
  op_t        obs_op [8];
  logic [2:0] obs_stage [8];
  logic       obs_ff [8];

  fused_seq_issuer #(.IDW(3), .DW(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_case(req_case), .req_a(req_a), .req_b(req_b),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_op(uop_op),
    .uop_imm(uop_imm), .uop_use_imm(uop_use_imm), .uop_a(uop_a), .uop_b(uop_b),
    .uop_ff(uop_ff), .uop_stage(uop_stage), .uop_last(uop_last),
    .busy(busy), .err(err)
`ifdef FUSED_SEQ_PERF_CNT_EN
    , .perf_uops(perf_uops), .perf_seqs(perf_seqs)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One legal sequence; mode 0 = always ready, 1 = toggle 1,0,1.., 2 = random.
  task automatic do_seq(input int c, input logic [31:0] a, input logic [31:0] b, input int mode);
    int len, stage, i, guard;
    bit tog, rdy;
    len = int'(LEN_LUT[c]); stage = 0; i = 0; guard = 0; tog = 1'b1;
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_case = c[2:0]; req_a = a; req_b = b;
    @(posedge clk); #1 req_valid = 1'b0;
    while (i < len && guard < 100) begin
      @(negedge clk);
      chk("uop_valid", uop_valid, 1);
      chk("busy", busy, 1);
      chk("ready_busy", req_ready, 0);
      chk("op", uop_op, OPS_LUT[c][i]);
      chk("imm", uop_imm, IMM_LUT[c][i]);
      chk("use_imm", uop_use_imm, USE_IMM_LUT[c][i]);
      chk("ff", uop_ff, FF_MASK_LUT[c][i]);
      chk("stage", uop_stage, stage);
      chk("last", uop_last, i == len - 1);
      chk("a", uop_a, a);
      chk("b", uop_b, b);
      case (mode)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = !tog; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      uop_ready = rdy;
      if (rdy) begin
        obs_op[i] = uop_op; obs_stage[i] = uop_stage; obs_ff[i] = uop_ff;
        if (i == len - 1) chk("final_stage", uop_stage, int'(STAGE_LUT[c]) - 1);
        stage += int'(FF_MASK_LUT[c][i]);
        i++;
        model_uops++;
      end
      guard++;
    end
    if (guard >= 100) chk("seq_timeout", 0, 1);
    else model_seqs++;
    @(negedge clk);
    uop_ready = 1'b0;
    chk("valid_after", uop_valid, 0);
    chk("busy_after", busy, 0);
    chk("ready_after", req_ready, 1);
  endtask

  task automatic do_illegal(input int c);
    @(negedge clk);
    req_valid = 1'b1; req_case = c[2:0];
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("err_pulse", err, 1);
    chk("err_valid", uop_valid, 0);
    chk("err_ready", req_ready, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_clear", err, 0);
    chk("err_valid2", uop_valid, 0);
  endtask

  initial begin
`ifdef FUSED_SEQ_PERF_CNT_EN
    logic [31:0] base_u, base_s;
`endif
    int c;
    // Reset values.
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", uop_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_last", uop_last, 0);
    chk("rst_ff", uop_ff, 0);
    chk("rst_stage", uop_stage, 0);
    chk("rst_op", uop_op, OP_NOP);
    chk("rst_imm", uop_imm, 0);
    chk("rst_use_imm", uop_use_imm, 0);
    chk("rst_a", uop_a, 0);
    chk("rst_b", uop_b, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_post_rst", req_ready, 1);

    // Case 0, always ready: IMUL then ADD, stage 0.
    req_valid = 1'b1; req_case = 3'd0; req_a = 32'h1111; req_b = 32'h2222;
    @(posedge clk); #1 req_valid = 1'b0; uop_ready = 1'b1;
    @(negedge clk);
    chk("c0_v0", uop_valid, 1); chk("c0_op0", uop_op, OP_IMUL);
    chk("c0_st0", uop_stage, 0); chk("c0_last0", uop_last, 0);
    @(negedge clk);
    chk("c0_op1", uop_op, OP_ADD); chk("c0_st1", uop_stage, 0); chk("c0_last1", uop_last, 1);
    @(negedge clk);
    chk("c0_ready", req_ready, 1); chk("c0_valid_end", uop_valid, 0);
    uop_ready = 1'b0; model_uops += 2; model_seqs++;

    // Case 4 with toggling ready; observed stream compared to known pattern.
    do_seq(4, 32'hcafe_0004, 32'hbeef_0004, 1);
    for (int k = 0; k < 6; k++) begin
      chk("c4_op", obs_op[k], (k < 3) ? OP_IMUL : OP_ADD);
      chk("c4_stage", obs_stage[k], (k < 3) ? k : 3);
      chk("c4_ff", obs_ff[k], k < 3);
    end

    // Illegal case.
    do_illegal(6);

    // Request held while case 5 issues: not accepted until after the third ADD.
    @(negedge clk);
    req_valid = 1'b1; req_case = 3'd5; req_a = 32'h55; req_b = 32'h66;
    @(posedge clk); #1 req_case = 3'd1; req_a = 32'h77; req_b = 32'h88; uop_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("c5_valid", uop_valid, 1); chk("c5_op", uop_op, OP_ADD);
      chk("c5_ready", req_ready, 0); chk("c5_a", uop_a, 32'h55);
      chk("c5_last", uop_last, k == 2);
    end
    @(negedge clk);
    chk("c5_end_valid", uop_valid, 0); chk("c5_end_ready", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("c1_op0", uop_op, OP_AND); chk("c1_a", uop_a, 32'h77); chk("c1_last0", uop_last, 0);
    @(negedge clk);
    chk("c1_op1", uop_op, OP_AND); chk("c1_last1", uop_last, 1);
    @(negedge clk);
    chk("c1_end", uop_valid, 0);
    uop_ready = 1'b0; model_uops += 5; model_seqs += 2;

    // Reset after the second uop of case 4.
    @(negedge clk);
    req_valid = 1'b1; req_case = 3'd4; req_a = 32'h4; req_b = 32'h44;
    @(posedge clk); #1 req_valid = 1'b0; uop_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_valid_pre", uop_valid, 1);
    rst = 1'b1; #1;
    chk("mid_rst_valid", uop_valid, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0); chk("mid_rst_op", uop_op, OP_NOP);
    chk("mid_rst_stage", uop_stage, 0);
    model_uops = 0; model_seqs = 0;
    uop_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("ready_low_release", req_ready, 0);
    @(negedge clk);
    chk("ready_rise_release", req_ready, 1);
    chk("no_uop_after_rst", uop_valid, 0);
    do_seq(1, 32'h0bad_0001, 32'h0bad_0002, 0);

`ifdef FUSED_SEQ_PERF_CNT_EN
    base_u = perf_uops; base_s = perf_seqs;
    do_seq(0, 32'h10, 32'h20, 0);
    do_seq(4, 32'h30, 32'h40, 0);
    do_seq(5, 32'h50, 32'h60, 0);
    chk("perf_uops_11", perf_uops - base_u, 11);
    chk("perf_seqs_3", perf_seqs - base_s, 3);
`endif

    // Random sequences with random backpressure.
    for (int n = 0; n < 25; n++) begin
      c = int'($urandom_range(0, 7));
      if (c >= N_CASE) do_illegal(c);
      else do_seq(c, $urandom, $urandom, 2);
    end

`ifdef FUSED_SEQ_PERF_CNT_EN
    chk("perf_uops_total", perf_uops, model_uops);
    chk("perf_seqs_total", perf_seqs, model_seqs);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
